timer_digit_entry: RTL and testbench

Sequential stage directly downstream of the keypad priority encoder in the timer-entry/control path. Takes the encoder's 4-bit BCD code plus a key-present indication, debounces each press, and shifts each accepted digit into a 4-digit MM:SS BCD register. The next stage (the countdown timer) loads from this register. Exactly one digit is accepted per physical press, however long the key is held.

---
 rtl/timer_digit_entry.sv | 126 ++++++++++++
 tb/tb_timer_digit_entry.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/timer_digit_entry.sv
// ============================================================================
// Module      : timer_digit_entry
// Description : Debounces keypad presses and shifts each accepted BCD digit
//               into a 4-digit MM:SS register. Optional: LEADING_ZERO_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_digit_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] D,
    input  logic       key_valid,
    input  logic       enablen,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       digit_strobe,
    output logic [2:0] entry_count
);

    localparam logic [3:0] C_DEB    = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] C_DEB_M1 = 4'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        ACCEPT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       w_skip;
    logic       w_take;

`ifdef LEADING_ZERO_SKIP_EN
    assign w_skip = (entry_count == 3'd0) && (D == 4'd0);
`else
    assign w_skip = 1'b0;
`endif

    // Non-BCD codes are silently rejected; the FSM still waits for release.
    assign w_take = (D <= 4'd9) && !w_skip;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            sec_ones     <= 4'd0;
            sec_tens     <= 4'd0;
            min_ones     <= 4'd0;
            min_tens     <= 4'd0;
            digit_strobe <= 1'b0;
            entry_count  <= 3'd0;
        end else begin
            digit_strobe <= 1'b0;
            if (clear) begin
                // Park in WAIT_RELEASE so a key held through clear is not taken.
                sec_ones    <= 4'd0;
                sec_tens    <= 4'd0;
                min_ones    <= 4'd0;
                min_tens    <= 4'd0;
                entry_count <= 3'd0;
                r_state     <= WAIT_RELEASE;
                r_cnt       <= 4'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (key_valid && !enablen) begin
                            r_state <= DEBOUNCE;
                            r_cnt   <= 4'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!key_valid) begin
                            r_state <= IDLE;
                            r_cnt   <= 4'd0;
                        end else if (enablen) begin
                            r_state <= WAIT_RELEASE;
                            r_cnt   <= 4'd0;
                        end else if (r_cnt == C_DEB) begin
                            r_state <= ACCEPT;
                            if (w_take) begin
                                min_tens     <= min_ones;
                                min_ones     <= sec_tens;
                                sec_tens     <= sec_ones;
                                sec_ones     <= D;
                                digit_strobe <= 1'b1;
                                entry_count  <= (entry_count == 3'd4) ? 3'd4
                                                                      : entry_count + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    ACCEPT: begin
                        r_state <= WAIT_RELEASE;
                        r_cnt   <= 4'd0;
                    end
                    WAIT_RELEASE: begin
                        if (key_valid) begin
                            r_cnt <= 4'd0;
                        end else if (r_cnt == C_DEB_M1) begin
                            r_state <= IDLE;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_digit_entry.sv
// ============================================================================
// Module      : tb_timer_digit_entry
// Description : Directed self-checking bench for timer_digit_entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_digit_entry;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] D;
    logic       key_valid;
    logic       enablen;
    logic       clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       digit_strobe;
    logic [2:0] entry_count;

    int checks    = 0;
    int failures  = 0;
    int strobes   = 0;
    int exp_count = 0;

    timer_digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .D            (D),
        .key_valid    (key_valid),
        .enablen      (enablen),
        .clear        (clear),
        .sec_ones     (sec_ones),
        .sec_tens     (sec_tens),
        .min_ones     (min_ones),
        .min_tens     (min_tens),
        .digit_strobe (digit_strobe),
        .entry_count  (entry_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (digit_strobe === 1'b1) strobes++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int rel);
        D         = d;
        key_valid = 1'b1;
        tick(hold);
        key_valid = 1'b0;
        tick(rel);
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        reset = 1'b1; D = 4'd0; key_valid = 1'b0; enablen = 1'b0; clear = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_digits", 32'(digits()), 32'h0000);
        check("reset_strobe", 32'(digit_strobe), 32'd0);
        check("reset_count", 32'(entry_count), 32'd0);

        press(4'd1, 10, 10);
        press(4'd2, 10, 10);
        press(4'd3, 10, 10);
        press(4'd4, 10, 10);
        check("four_digits", 32'(digits()), 32'h1234);
        check("four_strobes", 32'(strobes), 32'd4);
        check("four_count", 32'(entry_count), 32'd4);

        press(4'd5, 10, 10);
        check("shift_digits", 32'(digits()), 32'h2345);
        check("shift_count", 32'(entry_count), 32'd4);
        check("shift_strobes", 32'(strobes), 32'd5);

        // Glitch shorter than the debounce window
        press(4'd7, 3, 10);
        check("glitch_strobes", 32'(strobes), 32'd5);
        check("glitch_digits", 32'(digits()), 32'h2345);

        // Long hold: strobe exactly on the 5th sampled edge (k+4)
        D = 4'd7;
        key_valid = 1'b1;
        tick(4);
        check("lat_pre_strobe", 32'(digit_strobe), 32'd0);
        check("lat_pre_digits", 32'(digits()), 32'h2345);
        tick(1);
        check("lat_strobe", 32'(digit_strobe), 32'd1);
        check("lat_digits", 32'(digits()), 32'h3457);
        tick(1);
        check("lat_strobe_drop", 32'(digit_strobe), 32'd0);
        tick(14);
        key_valid = 1'b0;
        tick(10);
        check("hold_one_strobe", 32'(strobes), 32'd6);

        // Entry disabled
        enablen = 1'b1;
        press(4'd8, 10, 10);
        check("disabled_strobes", 32'(strobes), 32'd6);
        enablen = 1'b0;
        D = 4'd8;
        key_valid = 1'b1;
        tick(2);
        enablen = 1'b1;
        tick(1);
        enablen = 1'b0;
        tick(15);
        check("mid_disable_strobes", 32'(strobes), 32'd6);
        key_valid = 1'b0;
        tick(10);
        check("mid_disable_digits", 32'(digits()), 32'h3457);
        check("mid_disable_after", 32'(strobes), 32'd6);

        // Clear on the edge that would enter ACCEPT
        D = 4'd9;
        key_valid = 1'b1;
        tick(4);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_digits", 32'(digits()), 32'h0000);
        check("clear_count", 32'(entry_count), 32'd0);
        check("clear_strobe", 32'(digit_strobe), 32'd0);
        tick(10);
        check("clear_held_strobes", 32'(strobes), 32'd6);
        check("clear_held_digits", 32'(digits()), 32'h0000);
        key_valid = 1'b0;
        tick(10);

        // Leading zero, then invalid code
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        press(4'd0, 10, 10);
        press(4'd9, 10, 10);
`ifdef LEADING_ZERO_SKIP_EN
        exp_count = 1;
`else
        exp_count = 2;
`endif
        check("lz_digits", 32'(digits()), 32'h0009);
        check("lz_count", 32'(entry_count), 32'(exp_count));
        check("lz_strobes", 32'(strobes), 32'(6 + exp_count));
        press(4'd12, 10, 10);
        check("bad_code_digits", 32'(digits()), 32'h0009);
        check("bad_code_count", 32'(entry_count), 32'(exp_count));
        check("bad_code_strobes", 32'(strobes), 32'(6 + exp_count));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
